// File: rtl/instr_fetch_bridge.sv
// Instruction-fetch bridge: core req/gnt + rvalid/rready onto a 1-cycle single-port RAM/boot-ROM,
// two fetches outstanding, loader write priority. Optional bus-error responses: INSTR_BRIDGE_ERR_EN.
module instr_fetch_bridge #(
   parameter int RAM_SIZE   = 131072,
   parameter int BOOT_BASE  = 131072,
   parameter int ROM_SIZE   = 4096,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE) + 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    instr_req_i,
   input  logic [31:0]             instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   output logic                    instr_err_o,
   input  logic                    instr_rready_i,
   input  logic                    ld_req_i,
   input  logic [31:0]             ld_addr_i,
   input  logic [DATA_WIDTH-1:0]   ld_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] ld_be_i,
   output logic                    ld_gnt_o,
   output logic                    ram_en_o,
   output logic                    ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

   localparam logic [31:0] RAM_END = 32'(RAM_SIZE);
   localparam logic [31:0] BOOT_LO = 32'(BOOT_BASE);
   localparam logic [31:0] BOOT_HI = 32'(BOOT_BASE + ROM_SIZE);

   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [DATA_WIDTH-1:0] fifo_data_d [2];
   logic [1:0]            fifo_err_q;
   logic [1:0]            fifo_err_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_err_q, inflight_err_d;

   logic [31:0]           boot_off_s;
   logic                  boot_hit_s;
   logic                  ram_hit_s;
   logic                  ld_ram_hit_s;
   logic                  fetch_ok_s;
   logic [ADDR_WIDTH-1:0] fetch_addr_s;
   logic [1:0]            occ_s;
   logic                  rvalid_s;
   logic [DATA_WIDTH-1:0] rdata_s;
   logic                  err_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  fifo_pop_s;
   logic [DATA_WIDTH-1:0] resp_data_s;

   assign boot_off_s   = instr_addr_i - BOOT_LO;
   assign boot_hit_s   = (instr_addr_i >= BOOT_LO) && (instr_addr_i < BOOT_HI);
   assign ram_hit_s    = (instr_addr_i < RAM_END);
   assign ld_ram_hit_s = (ld_addr_i < RAM_END);
   assign fetch_addr_s = boot_hit_s ? {1'b1, boot_off_s[ADDR_WIDTH-2:0]}
                                    : {1'b0, instr_addr_i[ADDR_WIDTH-2:0]};
`ifdef INSTR_BRIDGE_ERR_EN
   assign fetch_ok_s = boot_hit_s | ram_hit_s;
`else
   assign fetch_ok_s = 1'b1;
`endif

   // Arbitration, memory command, response steering and FIFO next-state.
   always_comb begin
      instr_gnt_o    = 1'b0;
      ld_gnt_o       = 1'b0;
      ram_en_o       = 1'b0;
      ram_we_o       = 1'b0;
      ram_addr_o     = '0;
      ram_wdata_o    = '0;
      ram_be_o       = '0;
      rvalid_s       = 1'b0;
      rdata_s        = '0;
      err_s          = 1'b0;
      pop_s          = 1'b0;
      push_s         = 1'b0;
      fifo_pop_s     = 1'b0;
      occ_s          = cnt_q + {1'b0, inflight_q};
      resp_data_s    = inflight_err_q ? {DATA_WIDTH{1'b0}} : ram_rdata_i;
      fifo_data_d    = fifo_data_q;
      fifo_err_d     = fifo_err_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      cnt_d          = cnt_q;
      inflight_d     = 1'b0;
      inflight_err_d = 1'b0;
      if (rst_n) begin
         if (ld_req_i) begin
            ld_gnt_o = 1'b1;
            if (ld_ram_hit_s) begin
               ram_en_o    = 1'b1;
               ram_we_o    = 1'b1;
               ram_addr_o  = {1'b0, ld_addr_i[ADDR_WIDTH-2:0]};
               ram_wdata_o = ld_wdata_i;
               ram_be_o    = ld_be_i;
            end else begin
               ram_en_o = 1'b0;
            end
         end else if (instr_req_i && (occ_s < 2'd2)) begin
            instr_gnt_o    = 1'b1;
            inflight_d     = 1'b1;
            inflight_err_d = ~fetch_ok_s;
            if (fetch_ok_s) begin
               ram_en_o   = 1'b1;
               ram_addr_o = fetch_addr_s;
            end else begin
               ram_en_o = 1'b0;
            end
         end else begin
            instr_gnt_o = 1'b0;
         end

         // FIFO head has priority over the word arriving from memory to keep grant order.
         if (cnt_q != 2'd0) begin
            rvalid_s = 1'b1;
            rdata_s  = fifo_data_q[rd_ptr_q];
            err_s    = fifo_err_q[rd_ptr_q];
         end else if (inflight_q) begin
            rvalid_s = 1'b1;
            rdata_s  = resp_data_s;
            err_s    = inflight_err_q;
         end else begin
            rvalid_s = 1'b0;
         end

         pop_s      = rvalid_s & instr_rready_i;
         fifo_pop_s = pop_s & (cnt_q != 2'd0);
         push_s     = inflight_q & ~((cnt_q == 2'd0) & instr_rready_i);
         if (push_s) begin
            fifo_data_d[wr_ptr_q] = resp_data_s;
            fifo_err_d[wr_ptr_q]  = inflight_err_q;
            wr_ptr_d              = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (fifo_pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         cnt_d = cnt_q + {1'b0, push_s} - {1'b0, fifo_pop_s};
      end else begin
         cnt_d = 2'd0;
      end
   end

   assign instr_rvalid_o = rvalid_s;
   assign instr_rdata_o  = rdata_s;
`ifdef INSTR_BRIDGE_ERR_EN
   assign instr_err_o = err_s;
`else
   assign instr_err_o = 1'b0;
`endif

   // Response FIFO, pointers, occupancy and in-flight tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
         end
         fifo_err_q     <= 2'b00;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         cnt_q          <= 2'd0;
         inflight_q     <= 1'b0;
         inflight_err_q <= 1'b0;
      end else begin
         fifo_data_q    <= fifo_data_d;
         fifo_err_q     <= fifo_err_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         cnt_q          <= cnt_d;
         inflight_q     <= inflight_d;
         inflight_err_q <= inflight_err_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_bridge.sv
// Bench for instr_fetch_bridge: memory stand-in, byte-address reference model, scenario tasks.
module tb_instr_fetch_bridge;
   localparam int RAM_SIZE  = 131072;
   localparam int BOOT_BASE = 131072;
   localparam int ROM_SIZE  = 4096;
   localparam int AW        = 18;
   localparam int DW        = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_req_i = 1'b0;
   logic [31:0]   instr_addr_i = 32'h0;
   logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [DW-1:0] instr_rdata_o;
   logic          instr_rready_i = 1'b1;
   logic          ld_req_i = 1'b0;
   logic [31:0]   ld_addr_i = 32'h0;
   logic [DW-1:0] ld_wdata_i = 32'h0;
   logic [3:0]    ld_be_i = 4'h0;
   logic          ld_gnt_o, ram_en_o, ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_wdata_o;
   logic [3:0]    ram_be_o;
   logic [DW-1:0] mem_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .instr_rready_i(instr_rready_i),
      .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i), .ld_be_i(ld_be_i),
      .ld_gnt_o(ld_gnt_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(mem_rdata)
   );

   function automatic logic [31:0] ram_pat(int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] rom_pat(int i);
      return 32'hB007_0000 | 32'(i);
   endfunction

   // Memory stand-in: RAM + boot ROM, one-cycle read latency.
   logic [31:0] ram_mem [RAM_SIZE/4];
   logic [31:0] rom_mem [ROM_SIZE/4];
   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            if (!ram_addr_o[AW-1]) begin
               for (int b = 0; b < 4; b++)
                  if (ram_be_o[b]) ram_mem[ram_addr_o[AW-2:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end
         end else if (ram_addr_o[AW-1]) begin
            mem_rdata <= rom_mem[ram_addr_o[11:2]];
         end else begin
            mem_rdata <= ram_mem[ram_addr_o[AW-2:2]];
         end
      end
   end

   // Reference model: byte-address view of memory contents plus loader writes.
   logic [31:0] wr_map [int];
   logic [32:0] exp_q [$];

   function automatic logic [32:0] exp_resp(logic [31:0] a);
      int idx;
      if (a >= 32'(BOOT_BASE) && a < 32'(BOOT_BASE + ROM_SIZE))
         return {1'b0, rom_pat(int'((a - 32'(BOOT_BASE)) >> 2))};
`ifdef INSTR_BRIDGE_ERR_EN
      if (a >= 32'(RAM_SIZE)) return {1'b1, 32'h0};
`endif
      idx = int'((a % 32'(RAM_SIZE)) >> 2);
      return {1'b0, wr_map.exists(idx) ? wr_map[idx] : ram_pat(idx)};
   endfunction

   logic        eg_m;
   logic        pop_m;
   logic [31:0] cur_m;
   int          idx_m;
   // Scoreboard: grant rule, rvalid, ordered response data, loader grant.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         eg_m  = instr_req_i & ~ld_req_i & (exp_q.size() < 2);
         pop_m = (exp_q.size() > 0) & instr_rready_i;
         checks++;
         if (instr_gnt_o !== eg_m) begin
            errors++;
            $display("FAIL gnt t=%0t: got %b want %b", $time, instr_gnt_o, eg_m);
         end
         checks++;
         if (instr_rvalid_o !== (exp_q.size() > 0)) begin
            errors++;
            $display("FAIL rvalid t=%0t: got %b want %b", $time, instr_rvalid_o, exp_q.size() > 0);
         end
         checks++;
         if (ld_gnt_o !== ld_req_i) begin
            errors++;
            $display("FAIL ld_gnt t=%0t: got %b want %b", $time, ld_gnt_o, ld_req_i);
         end
         if (pop_m) begin
            checks++;
            if ({instr_err_o, instr_rdata_o} !== exp_q[0]) begin
               errors++;
               $display("FAIL resp t=%0t: got err=%b data=%h want err=%b data=%h",
                        $time, instr_err_o, instr_rdata_o, exp_q[0][32], exp_q[0][31:0]);
            end
            void'(exp_q.pop_front());
         end
         if (ld_req_i && ld_addr_i < 32'(RAM_SIZE)) begin
            idx_m = int'(ld_addr_i >> 2);
            cur_m = wr_map.exists(idx_m) ? wr_map[idx_m] : ram_pat(idx_m);
            for (int b = 0; b < 4; b++)
               if (ld_be_i[b]) cur_m[b*8 +: 8] = ld_wdata_i[b*8 +: 8];
            wr_map[idx_m] = cur_m;
         end
         if (eg_m) exp_q.push_back(exp_resp(instr_addr_i));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      instr_req_i    = 1'b0;
      ld_req_i       = 1'b0;
      instr_rready_i = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      instr_req_i = 1'b1;
      ld_req_i = 1'b1;
      ld_addr_i = 32'h10;
      ld_wdata_i = 32'hFFFF_FFFF;
      ld_be_i = 4'hF;
      #1;
      checks++;
      if ({instr_gnt_o, ld_gnt_o, instr_rvalid_o, instr_err_o, ram_en_o, ram_we_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 000000",
                  {instr_gnt_o, ld_gnt_o, instr_rvalid_o, instr_err_o, ram_en_o, ram_we_o});
      end
      checks++;
      if ({instr_rdata_o, ram_addr_o, ram_wdata_o, ram_be_o} !== 86'h0) begin
         errors++;
         $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%h want 0",
                  instr_rdata_o, ram_addr_o, ram_wdata_o, ram_be_o);
      end
      instr_req_i = 1'b0;
      ld_req_i = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sequential();
      instr_rready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         instr_req_i  = 1'b1;
         instr_addr_i = 32'(4 * i);
         #1;
         checks++;
         if (instr_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL seq_gnt%0d: got %b want 1", i, instr_gnt_o);
         end
         tick();
      end
      instr_req_i = 1'b0;
      #1;
      checks++;
      if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== ram_pat(2)) begin
         errors++;
         $display("FAIL seq_last: got v=%b d=%h want v=1 d=%h", instr_rvalid_o, instr_rdata_o, ram_pat(2));
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int a = 0;
      instr_rready_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         instr_req_i  = 1'b1;
         instr_addr_i = 32'h100 + 32'(4 * a);
         #1;
         if (instr_gnt_o) a++;
         tick();
      end
      checks++;
      if (a !== 2) begin
         errors++;
         $display("FAIL bp_held: got %0d grants want 2", a);
      end
      instr_rready_i = 1'b1;
      #1;
      checks++;
      if (instr_gnt_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_full_pop: got gnt %b want 0", instr_gnt_o);
      end
      tick();
      instr_rready_i = 1'b0;
      #1;
      checks++;
      if (instr_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_regrant: got gnt %b want 1", instr_gnt_o);
      end
      tick();
      drain();
   endtask

   task automatic test_boot();
      instr_rready_i = 1'b1;
      instr_req_i    = 1'b1;
      instr_addr_i   = 32'(BOOT_BASE) + 32'h10;
      #1;
      checks++;
      if (ram_en_o !== 1'b1 || ram_addr_o !== {1'b1, 17'h10}) begin
         errors++;
         $display("FAIL boot_addr: got en=%b addr=%h want en=1 addr=%h", ram_en_o, ram_addr_o, {1'b1, 17'h10});
      end
      tick();
      instr_req_i = 1'b0;
      #1;
      checks++;
      if (instr_rdata_o !== rom_pat(4)) begin
         errors++;
         $display("FAIL boot_data: got %h want %h", instr_rdata_o, rom_pat(4));
      end
      drain();
   endtask

   task automatic test_loader();
      instr_rready_i = 1'b1;
      ld_req_i = 1'b1;
      ld_addr_i = 32'h40;
      ld_wdata_i = 32'hDEAD_BEEF;
      ld_be_i = 4'hF;
      instr_req_i = 1'b1;
      instr_addr_i = 32'h80;
      #1;
      checks++;
      if ({ld_gnt_o, instr_gnt_o, ram_en_o, ram_we_o} !== 4'b1011 || ram_addr_o !== 18'h40
          || ram_wdata_o !== 32'hDEAD_BEEF || ram_be_o !== 4'hF) begin
         errors++;
         $display("FAIL ld_write: got gnts/en/we=%b addr=%h wdata=%h be=%h want 1011 40 deadbeef f",
                  {ld_gnt_o, instr_gnt_o, ram_en_o, ram_we_o}, ram_addr_o, ram_wdata_o, ram_be_o);
      end
      tick();
      ld_req_i = 1'b0;
      instr_addr_i = 32'h40;
      tick();
      ld_req_i = 1'b1;
      ld_addr_i = 32'h44;
      ld_wdata_i = 32'h1122_3344;
      ld_be_i = 4'b0101;
      instr_req_i = 1'b0;
      tick();
      ld_req_i = 1'b0;
      instr_req_i = 1'b1;
      instr_addr_i = 32'h44;
      tick();
      ld_req_i = 1'b1;
      ld_addr_i = 32'(BOOT_BASE);
      ld_wdata_i = 32'h0BAD_0BAD;
      ld_be_i = 4'hF;
      instr_req_i = 1'b0;
      #1;
      checks++;
      if (ram_en_o !== 1'b0 || ld_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL ld_boot_drop: got en=%b gnt=%b want en=0 gnt=1", ram_en_o, ld_gnt_o);
      end
      tick();
      ld_req_i = 1'b0;
      instr_req_i = 1'b1;
      instr_addr_i = 32'(BOOT_BASE);
      tick();
      instr_addr_i = 32'h0;
      tick();
      drain();
   endtask

   task automatic test_reset_mid();
      instr_rready_i = 1'b0;
      instr_req_i = 1'b1;
      instr_addr_i = 32'h200;
      tick();
      instr_addr_i = 32'h204;
      tick();
      instr_req_i = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (instr_rvalid_o !== 1'b0 || instr_gnt_o !== 1'b0 || instr_rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid: got v=%b g=%b d=%h want 0 0 0", instr_rvalid_o, instr_gnt_o, instr_rdata_o);
      end
      tick();
      instr_req_i = 1'b0;
      rst_n = 1'b1;
      instr_rready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (instr_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale%0d: got rvalid %b want 0", k, instr_rvalid_o);
         end
      end
   endtask

   task automatic test_err();
`ifdef INSTR_BRIDGE_ERR_EN
      instr_rready_i = 1'b1;
      instr_req_i = 1'b1;
      instr_addr_i = 32'h8;
      tick();
      instr_addr_i = 32'h1000_0000;
      #1;
      checks++;
      if (instr_gnt_o !== 1'b1 || ram_en_o !== 1'b0) begin
         errors++;
         $display("FAIL err_gnt: got gnt=%b en=%b want 1 0", instr_gnt_o, ram_en_o);
      end
      tick();
      instr_addr_i = 32'hC;
      #1;
      checks++;
      if (instr_err_o !== 1'b1 || instr_rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL err_resp: got err=%b d=%h want 1 0", instr_err_o, instr_rdata_o);
      end
      tick();
      drain();
`endif
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 600; c++) begin
         instr_rready_i = ($urandom % 4) != 0;
         instr_req_i    = ($urandom % 3) != 0;
         ld_req_i       = ($urandom % 8) == 0;
         r = int'($urandom % 8);
         if (r < 5)      instr_addr_i = 32'(($urandom % 64) * 4);
         else if (r < 7) instr_addr_i = 32'(BOOT_BASE) + 32'(($urandom % 1024) * 4);
`ifdef INSTR_BRIDGE_ERR_EN
         else            instr_addr_i = 32'h1000_0000 + 32'(($urandom % 64) * 4);
`else
         else            instr_addr_i = 32'h0004_0000 + 32'(($urandom % 64) * 4);
`endif
         ld_addr_i  = (($urandom % 6) == 0) ? 32'(BOOT_BASE) + 32'h20 : 32'(($urandom % 64) * 4);
         ld_wdata_i = $urandom;
         ld_be_i    = 4'($urandom % 16);
         tick();
      end
      drain();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d responses pending want 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < RAM_SIZE / 4; i++) ram_mem[i] = ram_pat(i);
      for (int i = 0; i < ROM_SIZE / 4; i++) rom_mem[i] = rom_pat(i);
      test_reset();
      test_sequential();
      test_back_to_back();
      test_boot();
      test_loader();
      test_reset_mid();
      test_err();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
